// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared types and constants for the PC sequencer.
//   seq_state_t      : sequencer FSM states (RUN, DRAIN, HALTED)
//   PC_STEP          : sequential fetch increment in bytes
//   DRAIN_CYCLES_DEF : default number of cycles in-flight work gets to retire after halt
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam int PC_STEP          = 4;
    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// sat_counter -- saturating up-counter used for sequencer statistics.
//   clk, reset : clock, asynchronous active-high reset (clears count)
//   inc        : increment enable, one count per cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch PC generation and IF/ID/EX pipeline control.
//   clk, reset      : clock, asynchronous active-high reset
//   stall           : load-use hazard; hold IF/ID and bubble ID/EX
//   redirect_valid  : branch resolved taken in EX; redirect_pc is the target
//   halt_req        : halt decoded in ID; drain the pipe then stop
//   pc              : registered fetch PC (PC_WIDTH bits)
//   pc_plus_4       : zero-extended pc + 4 (combinational, not wrapped)
//   stall_ifid, flush_ifid, flush_idex : pipeline register controls
//   misaligned      : target low bits nonzero on an accepted redirect
//   halted          : core stopped; only reset leaves this state
// Optional build macro PC_SEQ_STATS_EN adds saturating redirect_count and
// stall_count outputs.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH     = 9,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         pc_plus_4,
    output logic                stall_ifid,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic                misaligned,
    output logic                halted
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [15:0]         redirect_count,
    output logic [15:0]         stall_count
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // Count runs DRAIN_CYCLES-1 down to 0, so DRAIN lasts DRAIN_CYCLES cycles.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] redirect_target;

    logic stall_ifid_c, flush_ifid_c, flush_idex_c;
    logic redirect_acc, stall_acc;

    // Upper target bits beyond the PC width are dropped on purpose.
    assign redirect_target = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    generate
        if (PC_WIDTH < 32) begin : g_trunc
            logic unused_upper;
            assign unused_upper = ^redirect_pc[31:PC_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            pc_q        <= pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        pc_d         = pc_q;
        stall_ifid_c = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        redirect_acc = 1'b0;
        stall_acc    = 1'b0;
        case (state_q)
            RUN: begin
                // Redirect wins: a stall or halt alongside it is wrong-path.
                if (redirect_valid) begin
                    redirect_acc = 1'b1;
                    pc_d         = redirect_target;
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (stall) begin
                    stall_acc    = 1'b1;
                    stall_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (halt_req) begin
                    flush_ifid_c = 1'b1;
                    drain_cnt_d  = DRAIN_LOAD;
                    state_d      = DRAIN;
                end else begin
                    pc_d = pc_q + PC_WIDTH'(PC_STEP);
                end
            end
            DRAIN: begin
                // A redirect here means the branch was older than the halt.
                if (redirect_valid) begin
                    redirect_acc = 1'b1;
                    pc_d         = redirect_target;
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                    drain_cnt_d  = '0;
                    state_d      = RUN;
                end else begin
                    flush_ifid_c = 1'b1;
                    if (drain_cnt_q == '0)
                        state_d = HALTED;
                    else
                        drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                flush_ifid_c = 1'b1;
            end
            default: begin
                state_d     = RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    assign pc        = pc_q;
    assign pc_plus_4 = 32'(pc_q) + 32'(PC_STEP);
    assign halted    = (state_q == HALTED);

    // Reset forces the combinational controls low even if inputs are active.
    assign stall_ifid = stall_ifid_c & ~reset;
    assign flush_ifid = flush_ifid_c & ~reset;
    assign flush_idex = flush_idex_c & ~reset;
    assign misaligned = redirect_acc & (|redirect_pc[1:0]) & ~reset;

`ifdef PC_SEQ_STATS_EN
    sat_counter #(.WIDTH(16)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_acc),
        .count (redirect_count)
    );

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_acc),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- randomized and directed check of pc_sequencer against a
// cycle-level behavioural model (mode/remaining-drain-cycles abstraction).
module tb_pc_sequencer;

    localparam int PW = 9;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, halt_req;
    logic [31:0] redirect_pc;
    logic [PW-1:0] pc;
    logic [31:0] pc_plus_4;
    logic        stall_ifid, flush_ifid, flush_idex, misaligned, halted;
`ifdef PC_SEQ_STATS_EN
    logic [15:0] redirect_count, stall_count;
`endif

    pc_sequencer #(.PC_WIDTH(PW), .DRAIN_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .pc             (pc),
        .pc_plus_4      (pc_plus_4),
        .stall_ifid     (stall_ifid),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .misaligned     (misaligned),
        .halted         (halted)
`ifdef PC_SEQ_STATS_EN
        ,
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0=running, 1=draining, 2=stopped; m_left = drain cycles still to spend.
    int m_pc, m_mode, m_left, m_rc, m_sc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: assert reset mid-cycle with noisy inputs.
    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'($urandom);
        redirect_valid = 1'($urandom);
        redirect_pc    = $urandom;
        halt_req       = 1'($urandom);
        #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_pc4", pc_plus_4, 4);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_ctl", {stall_ifid, flush_ifid, flush_idex, misaligned}, 0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        redirect_pc = '0;
        m_pc = 0; m_mode = 0; m_left = 0; m_rc = 0; m_sc = 0;
`ifdef PC_SEQ_STATS_EN
        #1;
        chk("rst_rcnt", 32'(redirect_count), 0);
        chk("rst_scnt", 32'(stall_count), 0);
`endif
    endtask

    // One clock of stimulus: check outputs for this cycle, then advance the model.
    task automatic step(input logic st, input logic rv, input logic [31:0] rpc, input logic hr);
        int e_si, e_fi, e_fx, e_mis, n_pc;
        stall = st; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
        e_si = 0; e_fi = 0; e_fx = 0; e_mis = 0;
        n_pc = m_pc;
        if (m_mode != 2 && rv) begin
            e_fi = 1; e_fx = 1;
            e_mis = (rpc % 4 != 0) ? 1 : 0;
            n_pc = int'(rpc % (1 << PW)) / 4 * 4;
            m_rc++;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                e_si = 1; e_fx = 1; m_sc++;
            end else if (hr) begin
                e_fi = 1; m_mode = 1; m_left = DC;
            end else begin
                n_pc = (m_pc + 4) % (1 << PW);
            end
        end else if (m_mode == 1) begin
            e_fi = 1;
            m_left--;
            if (m_left == 0) m_mode = 2;
        end else begin
            e_fi = 1;
        end
        #1;
        chk("pc", 32'(pc), m_pc);
        chk("pc_plus_4", pc_plus_4, m_pc + 4);
        chk("stall_ifid", 32'(stall_ifid), e_si);
        chk("flush_ifid", 32'(flush_ifid), e_fi);
        chk("flush_idex", 32'(flush_idex), e_fx);
        chk("misaligned", 32'(misaligned), e_mis);
        @(posedge clk);
        m_pc = n_pc;
        @(negedge clk);
        #1;
        chk("halted", 32'(halted), (m_mode == 2) ? 1 : 0);
`ifdef PC_SEQ_STATS_EN
        chk("redirect_count", 32'(redirect_count), (m_rc > 65535) ? 65535 : m_rc);
        chk("stall_count", 32'(stall_count), (m_sc > 65535) ? 65535 : m_sc);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        do_reset();

        // Free-running fetch after reset.
        chk("seq_pc0", 32'(pc), 32'h0);
        idle(1); chk("seq_pc4", 32'(pc), 32'h4);
        idle(1); chk("seq_pc8", 32'(pc), 32'h8);
        idle(1); chk("seq_pc12", 32'(pc), 32'hC);

        // Misaligned redirect from 0x20.
        jump(32'h20); chk("jmp_pc20", 32'(pc), 32'h20);
        jump(32'h0000_0102); chk("mis_pc100", 32'(pc), 32'h100);

        // Two-cycle stall at 0x40.
        do_reset();
        jump(32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_hold", 32'(pc), 32'h40);
        idle(1); chk("stall_release", 32'(pc), 32'h44);
`ifdef PC_SEQ_STATS_EN
        chk("stall_cnt2", 32'(stall_count), 2);
`endif

        // Halt at 0x80, drain, then stop; redirect afterwards is ignored.
        do_reset();
        jump(32'h80);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(2); chk("drain_not_halted", 32'(halted), 0);
        idle(1); chk("halted_set", 32'(halted), 1);
        chk("halted_pc", 32'(pc), 32'h80);
        jump(32'h10); chk("halted_ign_pc", 32'(pc), 32'h80);
        step(1'b1, 1'b0, 32'h0, 1'b1); chk("halted_stays", 32'(halted), 1);

        // Reset while stopped returns to fresh fetch.
        do_reset();
        idle(2); chk("post_halt_pc", 32'(pc), 32'h8);

        // Redirect in the second drain cycle cancels the halt.
        jump(32'h80);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(1);
        jump(32'h10);
        chk("cancel_pc", 32'(pc), 32'h10);
        chk("cancel_halted", 32'(halted), 0);
        idle(4); chk("cancel_run", 32'(pc), 32'h20);

        // Reset mid-drain leaves no residual count.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(1);
        do_reset();
        idle(DC + 1); chk("drain_rst_pc", 32'(pc), 32'(4 * (DC + 1)));

        // Wrap at top of the PC space, then redirect beats stall.
        jump(32'h1FC);
        idle(1); chk("wrap_pc", 32'(pc), 32'h0);
        step(1'b1, 1'b1, 32'hFFFF_FE30, 1'b1);
        chk("rv_over_stall", 32'(pc), 32'h30);
`ifdef PC_SEQ_STATS_EN
        chk("rv_stall_cnt", 32'(stall_count), 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        st, rv, hr;
            logic [31:0] rpc;
            st  = ($urandom_range(99) < 20);
            rv  = ($urandom_range(99) < 15);
            hr  = ($urandom_range(99) < 6);
            rpc = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(511));
            if ($urandom_range(99) < 2 || (m_mode == 2 && $urandom_range(99) < 25))
                do_reset();
            else
                step(st, rv, rpc, hr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 9, meaning the PC register width in bits.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 3, meaning the cycles allowed for in-flight instructions to retire after a halt.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  load-use hazard request from the hazard unit.
REQ-006 redirect_valid  input  1  branch-unit pc_sel from the EX stage.
REQ-007 redirect_pc  input  32  branch-unit target address.
REQ-008 halt_req  input  1  halt instruction decoded in ID.
REQ-009 pc  output  PC_WIDTH  current fetch PC (registered).
REQ-010 pc_plus_4  output  32  zero-extended pc + 4 (combinational).
REQ-011 stall_ifid  output  1  hold the IF/ID register.
REQ-012 flush_ifid  output  1  clear the IF/ID register.
REQ-013 flush_idex  output  1  insert a bubble into ID/EX.
REQ-014 misaligned  output  1  one-cycle pulse when the accepted redirect_pc[1:0] is nonzero.
REQ-015 halted  output  1  core stopped.

Function
REQ-016 The FSM SHALL have states RUN, DRAIN and HALTED; the reset state SHALL be RUN.
REQ-017 In RUN with redirect_valid=1: pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; flush_ifid=1 and flush_idex=1 combinationally in that cycle.
REQ-018 In RUN, redirect SHALL take priority over stall and halt_req; both SHALL be ignored that cycle as wrong-path.
REQ-019 In RUN with stall=1 and no redirect: pc holds, stall_ifid=1, flush_idex=1, flush_ifid=0.
REQ-020 In RUN with halt_req=1, no redirect and no stall: pc holds, flush_ifid=1, the drain counter loads DRAIN_CYCLES-1, and the next state is DRAIN.
REQ-021 In RUN with no other event: pc <= pc+4, wrapping modulo 2^PC_WIDTH (the top PC maps to 0).
REQ-022 In DRAIN: pc holds, flush_ifid=1, and the counter decrements each cycle; at count 0 the next state is HALTED.
REQ-023 In DRAIN with redirect_valid=1, the halt SHALL be cancelled (the halt was younger than the branch): redirect is applied per REQ-017 and the next state is RUN.
REQ-024 In DRAIN, stall SHALL be ignored.
REQ-025 In HALTED: halted=1, pc holds, flush_ifid=1, and all inputs are ignored; only reset exits.
REQ-026 misaligned SHALL pulse only when a redirect is accepted; bits above PC_WIDTH-1 SHALL be truncated silently.
REQ-027 Outputs other than pc and halted SHALL be combinational from the current state and inputs.

Reset
REQ-028 reset=1 SHALL force asynchronously: pc=0, state=RUN, counter=0, halted=0, misaligned=0, and all stall/flush outputs 0 (pc_plus_4=4).
REQ-029 Reset asserted during DRAIN or HALTED SHALL return the block to RUN with pc=0 on deassertion, with no residual drain count.

Configuration
REQ-030 Macro PC_SEQ_STATS_EN SHALL, when defined, add outputs redirect_count[15:0] and stall_count[15:0].
REQ-031 redirect_count SHALL increment on each accepted redirect, and stall_count on each RUN stall cycle; both SHALL saturate at 16'hFFFF and clear on reset.
REQ-032 Without PC_SEQ_STATS_EN, both counter ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-033 Package pc_seq_pkg SHALL hold the state enum (RUN, DRAIN, HALTED), PC_STEP=4, and the default DRAIN_CYCLES value.
REQ-034 Counters SHALL use one sub-module, sat_counter (16-bit, increment enable, saturating), instantiated twice under the macro.

Verification
REQ-035 Reset released with no inputs asserted for 3 cycles -> pc = 0, 4, 8, 12; all flushes 0.
REQ-036 At pc=0x20, redirect_valid=1 with redirect_pc=0x0000_0102 -> flush_ifid=flush_idex=1, misaligned=1, next pc=0x100.
REQ-037 stall=1 for 2 cycles at pc=0x40 -> pc stays 0x40, stall_ifid=flush_idex=1 both cycles, then pc=0x44; with the macro defined, stall_count=2.
REQ-038 halt_req=1 at pc=0x80 -> DRAIN for 3 cycles, then halted=1 with pc still 0x80; subsequent redirect_valid=1 -> no change.
REQ-039 halt_req, then redirect_valid=1 with redirect_pc=0x10 in the second DRAIN cycle -> state RUN, pc=0x10, halted never asserts.
REQ-040 pc=0x1FC with PC_WIDTH=9 and no events -> next pc=0x000; separately, redirect_valid and stall together -> redirect applied, stall_count unchanged.
